fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 88 ++++++++
 tb/tb_fifo_rd_stream.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain half of an async FIFO: synchronizes the Gray write pointer, tracks
// the read pointer, and presents memory words through a one-entry ready/valid output register.
module fifo_rd_stream #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam int unsigned PW = ADDRSIZE + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [PW-1:0]       rq1_wptr_q, rq1_wptr_d;
  logic [PW-1:0]       rq2_wptr_q, rq2_wptr_d;
  logic [PW-1:0]       rbin_q, rbin_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                pop;
  logic [PW-1:0]       rgray_next;

  // Pop whenever memory has data and the output register is free or being drained.
  always_comb begin
    rq1_wptr_d   = wptr;
    rq2_wptr_d   = rq1_wptr_q;
    pop          = !rempty_q && (!dout_valid_q || dout_ready);
    rbin_d       = rbin_q + PW'(pop);
    rgray_next   = (rbin_d >> 1) ^ rbin_d;
    rptr_d       = rgray_next;
    rempty_d     = (rgray_next == rq2_wptr_q);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (pop) begin
      dout_d       = rdata;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1_wptr_q   <= '0;
      rq2_wptr_q   <= '0;
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rq1_wptr_q   <= rq1_wptr_d;
      rq2_wptr_q   <= rq2_wptr_d;
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Occupancy uses the synchronized write pointer, so it lags real writes by two edges.
  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rcount     = gray2bin(rq2_wptr_q) - rbin_q;
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: models the FIFO memory and write pointer,
// checks latency, draining, streaming across pointer wrap and reset behaviour.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          rclk;
  logic          rrst;
  logic [AW:0]   wptr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [AW:0]   rcount;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  logic [DW-1:0] mem [16];
  logic [AW:0]   wbin;
  int            n_tests;
  int            n_fail;

  fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .wptr       (wptr),
    .rdata      (rdata),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .rcount     (rcount),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  assign rdata = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    wbin = wbin + 1'b1;
    wptr = gray(wbin);
  endtask

  task automatic do_reset();
    rrst       = 1'b1;
    wbin       = '0;
    wptr       = '0;
    dout_ready = 1'b0;
    tick(2);
    rrst = 1'b0;
  endtask

  initial begin
    int consumed;
    int written;
    n_tests    = 0;
    n_fail     = 0;
    rrst       = 1'b1;
    wbin       = '0;
    wptr       = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values and idle behaviour with an empty memory
    #1;
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_valid",  32'(dout_valid), 32'd0);
    check("rst_rcount", 32'(rcount), 32'd0);
    check("rst_raddr",  32'(raddr), 32'd0);
    check("rst_rptr",   32'(rptr), 32'd0);
    tick(2);
    rrst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dout_ready = 1'(i);
      tick(1);
      check("idle_rempty", 32'(rempty), 32'd1);
      check("idle_raddr",  32'(raddr), 32'd0);
    end
    check("idle_valid",  32'(dout_valid), 32'd0);
    check("idle_rcount", 32'(rcount), 32'd0);
    check("idle_rptr",   32'(rptr), 32'd0);

    // Single word latency
    dout_ready = 1'b1;
    write_word(8'hA5);
    tick(1);
    check("lat_rcount_n0", 32'(rcount), 32'd0);
    tick(1);
    check("lat_rcount_n1", 32'(rcount), 32'd1);
    check("lat_rempty_n1", 32'(rempty), 32'd1);
    tick(1);
    check("lat_rempty_n2", 32'(rempty), 32'd0);
    check("lat_valid_n2",  32'(dout_valid), 32'd0);
    tick(1);
    check("lat_valid_n3",  32'(dout_valid), 32'd1);
    check("lat_dout_n3",   32'(dout), 32'hA5);
    check("lat_rptr_n3",   32'(rptr), 32'd1);
    check("lat_rempty_n3", 32'(rempty), 32'd1);
    check("lat_raddr_n3",  32'(raddr), 32'd1);
    tick(1);
    check("lat_valid_n4",  32'(dout_valid), 32'd0);
    check("lat_dout_hold", 32'(dout), 32'hA5);

    // Full memory with consumer stalled, then drained back to back
    do_reset();
    for (int k = 0; k < 16; k++) write_word(8'(8'h40 + k));
    tick(6);
    check("full_valid",  32'(dout_valid), 32'd1);
    check("full_dout",   32'(dout), 32'h40);
    check("full_rcount", 32'(rcount), 32'd15);
    check("full_raddr",  32'(raddr), 32'd1);
    check("full_rempty", 32'(rempty), 32'd0);
    dout_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick(1);
      check("drain_valid", 32'(dout_valid), 32'd1);
      check("drain_dout",  32'(dout), 32'(8'h40 + k));
    end
    check("drain_rempty", 32'(rempty), 32'd1);
    check("drain_rcount", 32'(rcount), 32'd0);
    tick(1);
    check("drain_valid_end", 32'(dout_valid), 32'd0);

    // 40-word stream with random back-pressure, crossing the pointer wrap
    consumed = 0;
    written  = 0;
    for (int cyc = 0; cyc < 2000 && consumed < 40; cyc++) begin
      dout_ready = 1'($urandom_range(0, 1));
      if (dout_valid && dout_ready) begin
        check("stream_word", 32'(dout), 32'(8'h80 + consumed));
        consumed++;
      end
      if (written < 40 && (written - consumed) < 16) begin
        write_word(8'(8'h80 + written));
        written++;
      end
      tick(1);
    end
    check("stream_cnt", 32'(consumed), 32'd40);
    dout_ready = 1'b0;
    tick(4);
    check("stream_valid_end",  32'(dout_valid), 32'd0);
    check("stream_rempty_end", 32'(rempty), 32'd1);
    check("stream_rcount_end", 32'(rcount), 32'd0);
    check("stream_raddr_end",  32'(raddr), 32'(wbin[AW-1:0]));
    check("stream_rptr_end",   32'(rptr), 32'(gray(wbin)));

    // Reset while a word is held and five remain in memory
    for (int k = 0; k < 6; k++) write_word(8'(8'hD0 + k));
    tick(6);
    check("mid_valid",  32'(dout_valid), 32'd1);
    check("mid_dout",   32'(dout), 32'hD0);
    check("mid_rcount", 32'(rcount), 32'd5);
    rrst = 1'b1;
    #1;
    check("async_valid",  32'(dout_valid), 32'd0);
    check("async_dout",   32'(dout), 32'd0);
    check("async_rempty", 32'(rempty), 32'd1);
    check("async_rptr",   32'(rptr), 32'd0);
    check("async_raddr",  32'(raddr), 32'd0);
    check("async_rcount", 32'(rcount), 32'd0);
    mem[0] = 8'h5A;
    tick(2);
    rrst = 1'b0;
    check("rel_raddr", 32'(raddr), 32'd0);
    tick(4);
    check("rel_valid", 32'(dout_valid), 32'd1);
    check("rel_dout",  32'(dout), 32'h5A);
    check("rel_raddr_after", 32'(raddr), 32'd1);

    // Back-to-back flow with consumer always ready
    do_reset();
    dout_ready = 1'b1;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    write_word(8'h44);
    tick(4);
    check("b2b_valid0", 32'(dout_valid), 32'd1);
    check("b2b_dout0",  32'(dout), 32'h11);
    for (int k = 1; k < 4; k++) begin
      tick(1);
      check("b2b_valid", 32'(dout_valid), 32'd1);
      check("b2b_dout",  32'(dout), 32'(8'h11 * (k + 1)));
    end
    tick(1);
    check("b2b_valid_end", 32'(dout_valid), 32'd0);
    check("b2b_rptr_end",  32'(rptr), 32'(gray(5'd4)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
